frame_buffer_arbiter: RTL and testbench



---
 rtl/frame_buffer_arbiter.sv | 167 ++++++++++++++++
 tb/tb_frame_buffer_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter
// Shares one single-port frame-buffer BRAM between the VGA read path and the
// camera write path. Reads have strict priority and a fixed 3-cycle latency
// from request to RD_VALID_O. Camera writes are queued in a small FIFO and
// drained into cycles without a read (mostly blanking).
//
// Ports:
//   CLK_25_I, RST_N_I         : 25 MHz clock, synchronous active-low reset
//   ENABLE_I                  : low = no BRAM access is granted
//   RD_REQ_I/RD_ADDR_I        : read request/address, one pixel per cycle
//   RD_DATA_O/RD_VALID_O      : read pixel and its valid strobe
//   WR_VALID_I/WR_ADDR_I/WR_DATA_I/WR_READY_O : camera write beat, non-stalling
//   OVF_CLR_I/OVERFLOW_O      : sticky dropped-beat flag and its clear
//   FIFO_LEVEL_O              : words currently queued
//   BRAM_EN_O/BRAM_WE_O/BRAM_ADDR_O/BRAM_DIN_O/BRAM_DOUT_I : BRAM port
module frame_buffer_arbiter #(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 12,
  parameter int FIFO_AW = 4
) (
  input  logic               CLK_25_I,
  input  logic               RST_N_I,
  input  logic               ENABLE_I,
  input  logic               RD_REQ_I,
  input  logic [ADDR_W-1:0]  RD_ADDR_I,
  output logic [DATA_W-1:0]  RD_DATA_O,
  output logic               RD_VALID_O,
  input  logic               WR_VALID_I,
  input  logic [ADDR_W-1:0]  WR_ADDR_I,
  input  logic [DATA_W-1:0]  WR_DATA_I,
  output logic               WR_READY_O,
  input  logic               OVF_CLR_I,
  output logic               OVERFLOW_O,
  output logic [FIFO_AW:0]   FIFO_LEVEL_O,
  output logic               BRAM_EN_O,
  output logic               BRAM_WE_O,
  output logic [ADDR_W-1:0]  BRAM_ADDR_O,
  output logic [DATA_W-1:0]  BRAM_DIN_O,
  input  logic [DATA_W-1:0]  BRAM_DOUT_I
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   CNT_ZERO = {(FIFO_AW+1){1'b0}};

  typedef enum logic [1:0] {
    G_IDLE  = 2'd0,
    G_READ  = 2'd1,
    G_WRITE = 2'd2
  } grant_t;

  grant_t grant_r, grant_next_s;

  logic [ADDR_W+DATA_W-1:0] fifo_mem [DEPTH];
  logic [FIFO_AW-1:0]       wr_ptr_r, rd_ptr_r;
  logic [FIFO_AW:0]         count_r, count_next_s;
  logic                     full_s, push_s, pop_s, drop_s;

  logic                     bram_en_r, bram_we_r, bram_en_next_s, bram_we_next_s;
  logic [ADDR_W-1:0]        bram_addr_r, bram_addr_next_s;
  logic [DATA_W-1:0]        bram_din_r, bram_din_next_s;

  logic                     rd_pend2_r, rd_valid_r, overflow_r;
  logic [DATA_W-1:0]        rd_data_r;

  // Full is judged on the start-of-cycle count, so a same-cycle pop never
  // frees a slot early.
  assign full_s       = count_r[FIFO_AW];
  assign push_s       = WR_VALID_I & ~full_s;
  assign drop_s       = WR_VALID_I & full_s;
  assign pop_s        = (grant_next_s == G_WRITE);
  assign count_next_s = count_r + {{FIFO_AW{1'b0}}, push_s} - {{FIFO_AW{1'b0}}, pop_s};

  // Grant decision and the BRAM port values it will drive next cycle.
  always_comb begin
    grant_next_s     = G_IDLE;
    bram_addr_next_s = bram_addr_r;
    bram_din_next_s  = bram_din_r;
    bram_en_next_s   = 1'b0;
    bram_we_next_s   = 1'b0;
    if (ENABLE_I && RD_REQ_I) begin
      grant_next_s = G_READ;
    end else if (ENABLE_I && (count_r != CNT_ZERO)) begin
      grant_next_s = G_WRITE;
    end else begin
      grant_next_s = G_IDLE;
    end
    case (grant_next_s)
      G_READ: begin
        bram_en_next_s   = 1'b1;
        bram_addr_next_s = RD_ADDR_I;
      end
      G_WRITE: begin
        bram_en_next_s = 1'b1;
        bram_we_next_s = 1'b1;
        {bram_addr_next_s, bram_din_next_s} = fifo_mem[rd_ptr_r];
      end
      default: begin
        bram_en_next_s = 1'b0;
        bram_we_next_s = 1'b0;
      end
    endcase
  end

  // Grant state, BRAM port, FIFO bookkeeping, read pipeline and overflow flag.
  always_ff @(posedge CLK_25_I) begin
    if (!RST_N_I) begin
      grant_r     <= G_IDLE;
      bram_en_r   <= 1'b0;
      bram_we_r   <= 1'b0;
      bram_addr_r <= {ADDR_W{1'b0}};
      bram_din_r  <= {DATA_W{1'b0}};
      wr_ptr_r    <= {FIFO_AW{1'b0}};
      rd_ptr_r    <= {FIFO_AW{1'b0}};
      count_r     <= CNT_ZERO;
      rd_pend2_r  <= 1'b0;
      rd_valid_r  <= 1'b0;
      rd_data_r   <= {DATA_W{1'b0}};
      overflow_r  <= 1'b0;
    end else begin
      grant_r     <= grant_next_s;
      bram_en_r   <= bram_en_next_s;
      bram_we_r   <= bram_we_next_s;
      bram_addr_r <= bram_addr_next_s;
      bram_din_r  <= bram_din_next_s;
      count_r     <= count_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      // grant_r==G_READ is the cycle the BRAM is enabled; BRAM data appears
      // one cycle later and is registered the cycle after that.
      rd_pend2_r <= (grant_r == G_READ);
      rd_valid_r <= rd_pend2_r;
      if (rd_pend2_r) begin
        rd_data_r <= BRAM_DOUT_I;
      end
      // A drop wins over a clear in the same cycle.
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (OVF_CLR_I) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers are reset.
  always_ff @(posedge CLK_25_I) begin
    if (RST_N_I && push_s) begin
      fifo_mem[wr_ptr_r] <= {WR_ADDR_I, WR_DATA_I};
    end
  end

  // Ready is forced low while reset is held so no beat is accepted then.
  assign WR_READY_O   = RST_N_I & ~full_s;
  assign FIFO_LEVEL_O = count_r;
  assign OVERFLOW_O   = overflow_r;
  assign RD_DATA_O    = rd_data_r;
  assign RD_VALID_O   = rd_valid_r;
  assign BRAM_EN_O    = bram_en_r;
  assign BRAM_WE_O    = bram_we_r;
  assign BRAM_ADDR_O  = bram_addr_r;
  assign BRAM_DIN_O   = bram_din_r;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter with a behavioural 1-cycle BRAM.
// Inputs are driven and outputs sampled at the falling edge.
module tb_frame_buffer_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        rd_req = 1'b0;
  logic [16:0] rd_addr = 17'd0;
  logic [11:0] rd_data;
  logic        rd_valid;
  logic        wr_valid = 1'b0;
  logic [16:0] wr_addr = 17'd0;
  logic [11:0] wr_data = 12'd0;
  logic        wr_ready;
  logic        ovf_clr = 1'b0;
  logic        overflow;
  logic [4:0]  fifo_level;
  logic        bram_en, bram_we;
  logic [16:0] bram_addr;
  logic [11:0] bram_din;
  logic [11:0] bram_dout = 12'd0;

  logic [11:0] bram [0:131071];
  int          wr_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic        flag_a, flag_b;

  always #20 clk = ~clk;

  frame_buffer_arbiter dut (
    .CLK_25_I(clk), .RST_N_I(rst_n), .ENABLE_I(enable),
    .RD_REQ_I(rd_req), .RD_ADDR_I(rd_addr), .RD_DATA_O(rd_data), .RD_VALID_O(rd_valid),
    .WR_VALID_I(wr_valid), .WR_ADDR_I(wr_addr), .WR_DATA_I(wr_data), .WR_READY_O(wr_ready),
    .OVF_CLR_I(ovf_clr), .OVERFLOW_O(overflow), .FIFO_LEVEL_O(fifo_level),
    .BRAM_EN_O(bram_en), .BRAM_WE_O(bram_we), .BRAM_ADDR_O(bram_addr),
    .BRAM_DIN_O(bram_din), .BRAM_DOUT_I(bram_dout)
  );

  // Single-port BRAM with one cycle of read latency, plus a write counter.
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) begin
        bram[bram_addr] <= bram_din;
        wr_cnt <= wr_cnt + 1;
      end else begin
        bram_dout <= bram[bram_addr];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int addr, input int data);
    chk({tag, "_we"},   32'(bram_we), 32'd1);
    chk({tag, "_addr"}, 32'(bram_addr), 32'(addr));
    chk({tag, "_din"},  32'(bram_din), 32'(data));
  endtask

  task automatic push(input int addr, input int data);
    wr_valid = 1'b1;
    wr_addr  = 17'(addr);
    wr_data  = 12'(data);
  endtask

  initial begin
    bram[17'h00010] = 12'hABC;
    bram[17'h00020] = 12'h123;

    // Reset state.
    repeat (3) tick();
    chk("rst_en", 32'(bram_en), 32'd0);
    chk("rst_we", 32'(bram_we), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_addr", 32'(bram_addr), 32'd0);

    // 1: queue 6 words with arbiter disabled, then reset mid-traffic.
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      push(500 + i, 'h700 + i);
      tick();
    end
    wr_valid = 1'b0;
    chk("t1_level6", 32'(fifo_level), 32'd6);
    enable = 1'b1;
    rst_n  = 1'b0;
    #1;
    chk("t1_ready_in_rst", 32'(wr_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t1_rst_en", 32'(bram_en), 32'd0);
      chk("t1_rst_we", 32'(bram_we), 32'd0);
      chk("t1_rst_level", 32'(fifo_level), 32'd0);
      chk("t1_rst_ready", 32'(wr_ready), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("t1_ready_after", 32'(wr_ready), 32'd1);
    chk("t1_level_after", 32'(fifo_level), 32'd0);
    repeat (5) tick();
    chk("t1_no_writes", 32'(wr_cnt), 32'd0);

    // 2: single read, 3-cycle latency.
    rd_req  = 1'b1;
    rd_addr = 17'h00010;
    tick();
    chk("t2_en", 32'(bram_en), 32'd1);
    chk("t2_we", 32'(bram_we), 32'd0);
    chk("t2_addr", 32'(bram_addr), 32'h10);
    chk("t2_valid_n1", 32'(rd_valid), 32'd0);
    rd_req = 1'b0;
    tick();
    chk("t2_valid_n2", 32'(rd_valid), 32'd0);
    tick();
    chk("t2_valid_n3", 32'(rd_valid), 32'd1);
    chk("t2_data_n3", 32'(rd_data), 32'hABC);
    tick();
    chk("t2_valid_n4", 32'(rd_valid), 32'd0);
    chk("t2_data_hold", 32'(rd_data), 32'hABC);

    // 3: four writes drain in order, WE from n+2.
    push(100, 'h111);
    tick();
    chk("t3_we_n1", 32'(bram_we), 32'd0);
    chk("t3_level_n1", 32'(fifo_level), 32'd1);
    push(101, 'h222);
    tick();
    chk_wr("t3_w0", 100, 'h111);
    push(102, 'h333);
    tick();
    chk_wr("t3_w1", 101, 'h222);
    push(103, 'h444);
    tick();
    chk_wr("t3_w2", 102, 'h333);
    wr_valid = 1'b0;
    tick();
    chk_wr("t3_w3", 103, 'h444);
    tick();
    chk("t3_we_n6", 32'(bram_we), 32'd0);
    chk("t3_level_n6", 32'(fifo_level), 32'd0);

    // 4: 640 read cycles with 17 pushes; 17th dropped, then ordered drain.
    rd_req  = 1'b1;
    rd_addr = 17'h00020;
    flag_a  = 1'b0;
    for (int c = 0; c < 640; c++) begin
      if (c < 17) begin
        push(200 + c, 'h800 + c);
      end else begin
        wr_valid = 1'b0;
      end
      if (c == 16) begin
        chk("t4_ready_full", 32'(wr_ready), 32'd0);
      end
      tick();
      if (bram_we) flag_a = 1'b1;
    end
    chk("t4_no_we_in_reads", 32'(flag_a), 32'd0);
    chk("t4_level16", 32'(fifo_level), 32'd16);
    chk("t4_ready0", 32'(wr_ready), 32'd0);
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_rd_data", 32'(rd_data), 32'h123);
    rd_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_wr("t4_drain", 200 + i, 'h800 + i);
    end
    tick();
    chk("t4_we_end", 32'(bram_we), 32'd0);
    chk("t4_level_end", 32'(fifo_level), 32'd0);
    chk("t4_ready_end", 32'(wr_ready), 32'd1);

    // 5: overflow set wins over clear; clear alone clears.
    ovf_clr = 1'b1;
    tick();
    chk("t5_clr_first", 32'(overflow), 32'd0);
    ovf_clr = 1'b0;
    enable  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push(300 + i, 'hA00 + i);
      tick();
    end
    chk("t5_level16", 32'(fifo_level), 32'd16);
    push(316, 'hA10);
    ovf_clr = 1'b1;
    tick();
    chk("t5_set_wins", 32'(overflow), 32'd1);
    wr_valid = 1'b0;
    tick();
    chk("t5_clr_alone", 32'(overflow), 32'd0);
    ovf_clr = 1'b0;
    enable  = 1'b1;
    repeat (17) tick();
    chk("t5_level_drained", 32'(fifo_level), 32'd0);
    chk("t5_wr_cnt", 32'(wr_cnt), 32'd36);
    chk("t5_addr_hold", 32'(bram_addr), 32'd315);
    chk("t5_din_hold", 32'(bram_din), 32'hA0F);

    // 6: disabled arbiter ignores reads, keeps queuing; enable drains 3.
    enable  = 1'b0;
    rd_req  = 1'b1;
    rd_addr = 17'h00010;
    flag_a  = 1'b0;
    flag_b  = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        push(400 + c, 'h900 + c);
      end else begin
        wr_valid = 1'b0;
      end
      tick();
      if (bram_en) flag_a = 1'b1;
      if (rd_valid) flag_b = 1'b1;
    end
    chk("t6_no_en", 32'(flag_a), 32'd0);
    chk("t6_no_valid", 32'(flag_b), 32'd0);
    chk("t6_level3", 32'(fifo_level), 32'd3);
    rd_req = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_wr("t6_drain", 400 + i, 'h900 + i);
    end
    tick();
    chk("t6_en_end", 32'(bram_en), 32'd0);
    chk("t6_level_end", 32'(fifo_level), 32'd0);
    chk("t6_wr_cnt", 32'(wr_cnt), 32'd39);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
